// File: rtl/sample0_mac_pipe.sv
// Pipelined signed multiply-accumulate with valid tagging, dot-product
// accumulation, output scaling and optional saturation.
module sample0_mac_pipe #(
  parameter int A_WIDTH   = 15,
  parameter int B_WIDTH   = 15,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 15,
  parameter int NUM_STAGE = 3,
  parameter int SHIFT     = 0,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  input  logic                 first,
  input  logic                 last,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 overflow
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  // Number of product stages (stages 2..NUM_STAGE).
  localparam int unsigned DEPTH = NUM_STAGE - 1;

  // Stage 1: registered operands and flags
  logic signed [A_WIDTH-1:0] a_s1;
  logic signed [B_WIDTH-1:0] b_s1;
  logic                      v_s1, f_s1, l_s1;

  // Stages 2..NUM_STAGE: full-precision product and flags; index 0 is stage 2
  logic signed [P_WIDTH-1:0] prod_pipe [DEPTH];
  logic [DEPTH-1:0]          v_pipe, f_pipe, l_pipe;
  logic signed [P_WIDTH-1:0] prod_new;

  // Accumulate stage
  logic signed [ACC_WIDTH-1:0] acc, prod_ext, sum;
  logic                        sticky, acc_last, add_ovf;
  logic signed [P_WIDTH-1:0]   prod_t;
  logic                        v_t, f_t, l_t;

  // Output scaling
  logic signed [ACC_WIDTH-1:0]        shifted;
  logic [ACC_WIDTH-OUT_WIDTH:0]       hi_bits;
  logic                               fits;
  logic [OUT_WIDTH-1:0]               dout_next;

  assign prod_new = P_WIDTH'(a_s1) * P_WIDTH'(b_s1);

  // Valid bits advance with ce and are cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      v_s1   <= 1'b0;
      v_pipe <= '0;
    end else if (ce) begin
      v_s1      <= in_valid;
      v_pipe[0] <= v_s1;
      for (int unsigned i = 1; i < DEPTH; i++) v_pipe[i] <= v_pipe[i-1];
    end
  end

  // Operand, product and flag payloads advance with ce; meaningful only when valid
  always_ff @(posedge clk) begin
    if (ce) begin
      a_s1         <= din0;
      b_s1         <= din1;
      f_s1         <= first;
      l_s1         <= last;
      prod_pipe[0] <= prod_new;
      f_pipe[0]    <= f_s1;
      l_pipe[0]    <= l_s1;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        prod_pipe[i] <= prod_pipe[i-1];
        f_pipe[i]    <= f_pipe[i-1];
        l_pipe[i]    <= l_pipe[i-1];
      end
    end
  end

  assign prod_t   = prod_pipe[DEPTH-1];
  assign v_t      = v_pipe[DEPTH-1];
  assign f_t      = f_pipe[DEPTH-1];
  assign l_t      = l_pipe[DEPTH-1];
  assign prod_ext = ACC_WIDTH'(prod_t);
  assign sum      = acc + prod_ext;
  assign add_ovf  = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

  // Accumulator: restart on first, wrap-add otherwise; bubbles leave it untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      sticky   <= 1'b0;
      acc_last <= 1'b0;
    end else if (ce) begin
      acc_last <= v_t & l_t;
      if (v_t) begin
        if (f_t) begin
          acc    <= prod_ext;
          sticky <= 1'b0;
        end else begin
          acc    <= sum;
          sticky <= sticky | add_ovf;
        end
      end
    end
  end

  assign shifted = acc >>> SHIFT;
  assign hi_bits = shifted[ACC_WIDTH-1:OUT_WIDTH-1];
  // Value is representable when all bits above the output sign bit match it.
  assign fits    = (&hi_bits) | ~(|hi_bits);

  // Scale and clamp (or wrap) the accumulator into the output width
  always_comb begin
    dout_next = shifted[OUT_WIDTH-1:0];
    if (SATURATE != 0 && !fits) begin
      dout_next = shifted[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                       : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  // Result register: one-cycle pulse after a completed vector, payload held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      overflow  <= 1'b0;
    end else if (ce) begin
      out_valid <= acc_last;
      if (acc_last) begin
        dout     <= dout_next;
        overflow <= sticky | ~fits;
      end
    end
  end

endmodule

// File: tb/tb_sample0_mac_pipe.sv
// Randomised and directed bench for sample0_mac_pipe: three instances
// (saturating, wrapping, SHIFT=4) checked against a transaction-level model.
module tb_sample0_mac_pipe;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, first, last;
  logic [14:0] din0, din1;
  logic [2:0]  ov;
  logic [2:0][14:0] dq;
  logic [2:0]  of;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sample0_mac_pipe #(.NUM_STAGE(N)) u_sat (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .first(first), .last(last), .out_valid(ov[0]), .dout(dq[0]), .overflow(of[0]));
  sample0_mac_pipe #(.NUM_STAGE(N), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .first(first), .last(last), .out_valid(ov[1]), .dout(dq[1]), .overflow(of[1]));
  sample0_mac_pipe #(.NUM_STAGE(N), .SHIFT(4)) u_shift (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .first(first), .last(last), .out_valid(ov[2]), .dout(dq[2]), .overflow(of[2]));

  typedef struct packed {
    int unsigned      due;
    logic [2:0]       vld;
    logic [2:0][14:0] d;
    logic [2:0]       ovf;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  localparam int SHV [3] = '{0, 0, 4};
  localparam int SATV[3] = '{1, 0, 1};

  // Reference model: dot products in 64-bit arithmetic, wrapped to 40 bits
  int unsigned ce_cnt = 0;
  longint m_acc = 0;
  bit     m_sticky = 1'b0;
  logic   mr, mc, mv, mf, ml;
  longint ma, mb, t, w, s, val;
  bit     fits;
  ev_t    e, o;

  always @(posedge clk) begin
    mr = reset; mc = ce; mv = in_valid; mf = first; ml = last;
    ma = longint'($signed(din0));
    mb = longint'($signed(din1));
    #1;
    if (mr) begin
      m_acc = 0;
      m_sticky = 1'b0;
      while (exp_q.size() > 0 && exp_q[$].due > ce_cnt) void'(exp_q.pop_back());
    end else if (mc) begin
      ce_cnt++;
      if (mv) begin
        if (mf) begin
          t = ma * mb;
          m_sticky = 1'b0;
        end else begin
          t = m_acc + ma * mb;
        end
        w = (t <<< 24) >>> 24;
        if (w != t) m_sticky = 1'b1;
        m_acc = w;
        if (ml) begin
          e.due = ce_cnt + N + 1;
          e.vld = 3'b111;
          for (int k = 0; k < 3; k++) begin
            s = m_acc >>> SHV[k];
            fits = (s >= -16384) && (s <= 16383);
            val = s;
            if (!fits && SATV[k] != 0) val = (s < 0) ? -16384 : 16383;
            e.d[k]   = 15'(val);
            e.ovf[k] = m_sticky | !fits;
          end
          exp_q.push_back(e);
        end
      end
      if (ov != 3'b000) begin
        o.due = ce_cnt;
        o.vld = ov;
        o.d   = dq;
        o.ovf = of;
        obs_q.push_back(o);
      end
    end
  end

  task automatic step(input logic c, input logic v, input int a, input int b,
                      input logic f, input logic l);
    ce = c; in_valid = v; din0 = 15'(a); din1 = 15'(b); first = f; last = l;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1; ce = 1'b0; in_valid = 1'b0; first = 1'b0; last = 1'b0;
    din0 = '0; din1 = '0;
    repeat (3) @(negedge clk);
    n_assert++;
    if (ov !== 3'b000) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 000", ov);
    end
    n_assert++;
    if (dq[0] !== 15'd0 || dq[1] !== 15'd0 || dq[2] !== 15'd0) begin
      n_fail++; $display("FAIL reset_dout: got %h expected 0", dq);
    end
    n_assert++;
    if (of !== 3'b000) begin
      n_fail++; $display("FAIL reset_overflow: got %b expected 000", of);
    end
    reset = 1'b0;
    exp_q.delete(); obs_q.delete();
    idle(N + 4);
    n_assert++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL reset_idle_outputs: got %0d expected 0", obs_q.size());
    end
  endtask

  task automatic test_single;
    int unsigned c0;
    exp_q.delete(); obs_q.delete();
    c0 = ce_cnt;
    step(1'b1, 1'b1, 3, -4, 1'b1, 1'b1);
    idle(N + 4);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL single_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL single_event: got %p expected %p", obs_q[i], exp_q[i]);
      end
    end
    n_assert++;
    if (obs_q.size() < 1 || obs_q[0].d[0] !== 15'(-12) || obs_q[0].ovf[0] !== 1'b0 ||
        obs_q[0].due !== c0 + 5) begin
      n_fail++; $display("FAIL single_literal: got %p expected dout=-12 ovf=0 due=%0d",
                         obs_q[0], c0 + 5);
    end
  endtask

  task automatic test_back_to_back;
    exp_q.delete(); obs_q.delete();
    step(1'b1, 1'b1, 1, 2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 3, 4, 1'b0, 1'b0);
    step(1'b1, 1'b1, -5, 6, 1'b0, 1'b1);
    step(1'b1, 1'b1, 7, 7, 1'b1, 1'b1);
    idle(N + 4);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_event: got %p expected %p", obs_q[i], exp_q[i]);
      end
    end
    n_assert++;
    if (obs_q.size() < 2 || obs_q[0].d[0] !== 15'(-16) || obs_q[1].d[0] !== 15'd49 ||
        obs_q[1].due !== obs_q[0].due + 1) begin
      n_fail++; $display("FAIL b2b_literal: got %p / %p expected -16 then 49 consecutive",
                         obs_q[0], obs_q[1]);
    end
  endtask

  task automatic test_stall;
    int unsigned c0;
    exp_q.delete(); obs_q.delete();
    c0 = ce_cnt;
    step(1'b1, 1'b1, 1, 2, 1'b1, 1'b0);
    step(1'b0, 1'b1, 99, 99, 1'b1, 1'b1);
    step(1'b0, 1'b1, -77, 55, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3, 4, 1'b0, 1'b0);
    step(1'b1, 1'b0, 11, 11, 1'b0, 1'b1);
    step(1'b1, 1'b1, -5, 6, 1'b0, 1'b1);
    idle(N + 4);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL stall_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL stall_event: got %p expected %p", obs_q[i], exp_q[i]);
      end
    end
    n_assert++;
    if (obs_q.size() < 1 || obs_q[0].d[0] !== 15'(-16) || obs_q[0].due !== c0 + 8) begin
      n_fail++; $display("FAIL stall_literal: got %p expected dout=-16 due=%0d", obs_q[0], c0 + 8);
    end
  endtask

  task automatic test_scaling;
    exp_q.delete(); obs_q.delete();
    step(1'b1, 1'b1, 16383, 16383, 1'b1, 1'b1);
    step(1'b1, 1'b1, -100, 3, 1'b1, 1'b1);
    step(1'b1, 1'b1, -16384, 1, 1'b1, 1'b1);
    step(1'b1, 1'b1, -16384, -16384, 1'b1, 1'b1);
    idle(N + 4);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL scale_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL scale_event: got %p expected %p", obs_q[i], exp_q[i]);
      end
    end
    n_assert++;
    if (obs_q.size() < 2 || obs_q[0].d[0] !== 15'h3FFF || obs_q[0].d[1] !== 15'd1 ||
        obs_q[0].ovf !== 3'b111) begin
      n_fail++; $display("FAIL scale_sat_literal: got %p expected d=3FFF/0001 ovf=111", obs_q[0]);
    end
    n_assert++;
    if (obs_q.size() < 2 || obs_q[1].d[2] !== 15'(-19) || obs_q[1].d[0] !== 15'(-300) ||
        obs_q[1].ovf !== 3'b000) begin
      n_fail++; $display("FAIL scale_shift_literal: got %p expected shift=-19 sat=-300 ovf=000",
                         obs_q[1]);
    end
  endtask

  task automatic test_acc_wrap;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 2048; i++)
      step(1'b1, 1'b1, -16384, -16384, (i == 0), (i == 2047));
    idle(N + 4);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wrap_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL wrap_event: got %p expected %p", obs_q[i], exp_q[i]);
      end
    end
    n_assert++;
    if (obs_q.size() < 1 || obs_q[0].ovf !== 3'b111 || obs_q[0].d[0] !== 15'h4000) begin
      n_fail++; $display("FAIL wrap_literal: got %p expected dout=4000 ovf=111", obs_q[0]);
    end
  endtask

  task automatic test_reset_mid;
    exp_q.delete(); obs_q.delete();
    step(1'b1, 1'b1, 1, 1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2, 2, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 1'b1, 3, 3, 1'b0, 1'b1);
    reset = 1'b0;
    step(1'b1, 1'b1, 2, 5, 1'b1, 1'b1);
    idle(N + 4);
    n_assert++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL rstmid_count: got %0d expected 1", obs_q.size());
    end
    n_assert++;
    if (obs_q.size() < 1 || obs_q[0] !== exp_q[0] || obs_q[0].d[0] !== 15'd10) begin
      n_fail++; $display("FAIL rstmid_event: got %p expected %p", obs_q[0], exp_q[0]);
    end
  endtask

  task automatic test_random;
    bit open = 1'b0;
    logic c, v, f, l;
    int a, b;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(7) != 0);
      v = ($urandom_range(3) != 0);
      if ($urandom_range(5) == 0) begin
        a = ($urandom_range(1) != 0) ? 16383 : -16384;
        b = ($urandom_range(1) != 0) ? 16383 : -16384;
      end else begin
        a = int'($urandom_range(32767)) - 16384;
        b = int'($urandom_range(32767)) - 16384;
      end
      f = open ? 1'b0 : ($urandom_range(7) != 0);
      l = ($urandom_range(2) == 0);
      step(c, v, a, b, f, l);
      if (c && v) open = !l;
    end
    step(1'b1, 1'b1, 5, -9, 1'b0, 1'b1);
    idle(N + 4);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL random_event %0d: got %p expected %p", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_stall;
    test_scaling;
    test_acc_wrap;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
